comp_serial: RTL and testbench



---
 rtl/comp_pkg.sv | 14 +
 rtl/comp_digit.sv | 27 ++
 rtl/comp_serial.sv | 109 ++++++++++
 tb/tb_comp_serial.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/comp_pkg.sv
// Shared result codes and FSM state type for the digit-serial comparator.
package comp_pkg;

  localparam logic [1:0] COMP_EQ = 2'b00;
  localparam logic [1:0] COMP_GT = 2'b01;
  localparam logic [1:0] COMP_LT = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/comp_digit.sv
// Combinational DIGIT-bit magnitude compare returning a comp_pkg result code;
// inv flips the digit MSB so a two's-complement top digit compares correctly.
module comp_digit
  import comp_pkg::*;
#(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             inv,
  output logic [1:0]       res
);

  logic [DIGIT-1:0] a_eff;
  logic [DIGIT-1:0] b_eff;

  always_comb begin
    a_eff            = a;
    b_eff            = b;
    a_eff[DIGIT-1]   = a[DIGIT-1] ^ inv;
    b_eff[DIGIT-1]   = b[DIGIT-1] ^ inv;
    if (a_eff > b_eff)      res = COMP_GT;
    else if (a_eff < b_eff) res = COMP_LT;
    else                    res = COMP_EQ;
  end

endmodule

// File: rtl/comp_serial.sv
// Digit-serial MSB-first magnitude comparator with start/ready/done handshake.
// Optional signed compare (sgn port) when COMP_SERIAL_SIGNED_EN is defined.
//
// state | meaning
// IDLE  | ready, waiting for start
// RUN   | comparing one digit per cycle
// DONE  | one-cycle done pulse, o valid
module comp_serial
  import comp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
`ifdef COMP_SERIAL_SIGNED_EN
  input  logic             sgn,
`endif
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [1:0]       o
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_N = CW'(N);
  localparam logic [CW-1:0] CNT_1 = CW'(1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sh_a, sh_b;
  logic [CW-1:0]    cnt;
  logic [1:0]       dig_res;
  logic             inv;
  logic             last;
  logic             finish;

`ifdef COMP_SERIAL_SIGNED_EN
  logic sgn_r;
  // Only the first (most significant) digit carries the sign.
  assign inv = sgn_r && (cnt == CNT_N);
`else
  assign inv = 1'b0;
`endif

  comp_digit #(.DIGIT(DIGIT)) u_digit (
    .a   (sh_a[WIDTH-1 -: DIGIT]),
    .b   (sh_b[WIDTH-1 -: DIGIT]),
    .inv (inv),
    .res (dig_res)
  );

  assign last   = (cnt == CNT_1);
  assign finish = (dig_res != COMP_EQ) || last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (finish) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_a  <= '0;
      sh_b  <= '0;
      cnt   <= '0;
      o     <= COMP_EQ;
`ifdef COMP_SERIAL_SIGNED_EN
      sgn_r <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          sh_a  <= a;
          sh_b  <= b;
          cnt   <= CNT_N;
`ifdef COMP_SERIAL_SIGNED_EN
          sgn_r <= sgn;
`endif
        end
        RUN: if (finish) begin
          o <= dig_res;
        end else begin
          sh_a <= sh_a << DIGIT;
          sh_b <= sh_b << DIGIT;
          cnt  <= cnt - CNT_1;
        end
        default: ;
      endcase
    end
  end

  assign ready = (state == IDLE);
  assign busy  = (state == RUN);
  assign done  = (state == DONE);

endmodule

// File: tb/tb_comp_serial.sv
// Directed self-checking bench for comp_serial (WIDTH=8, DIGIT=2).
module tb_comp_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic       sgn;
  logic       start;
  logic [7:0] a, b;
  logic       ready, busy, done;
  logic [1:0] o;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  comp_serial #(.WIDTH(8), .DIGIT(2)) dut (
    .clk   (clk),
    .rst   (rst),
`ifdef COMP_SERIAL_SIGNED_EN
    .sgn   (sgn),
`endif
    .start (start),
    .a     (a),
    .b     (b),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .o     (o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int first_diff(input logic [7:0] x, input logic [7:0] y);
    for (int i = 0; i < 4; i++)
      if (x[7-2*i -: 2] != y[7-2*i -: 2]) return i + 1;
    return 4;
  endfunction

  // Issue one comparison and check result, latency, done width and ready return.
  task automatic run_cmp(input string tag, input logic [7:0] va, input logic [7:0] vb,
                         input logic s, input logic [1:0] eo, input int ek);
    int n;
    a = va; b = vb; sgn = s; start = 1'b1;
    tick();
    start = 1'b0; a = ~va; b = ~vb; sgn = ~s;
    n = 0;
    while (!done && n < 20) begin
      check({tag, "_busy"}, {30'd0, busy, ready}, 32'd2);
      tick();
      n++;
    end
    check({tag, "_lat"}, n, ek);
    check({tag, "_o"}, o, eo);
    tick();
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_ready"}, ready, 1'b1);
    check({tag, "_o_hold"}, o, eo);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; sgn = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      check("idle", {28'd0, ready, busy, done, 1'b0, o}, {28'd0, 4'b1000, 2'b00});
      tick();
    end

    run_cmp("c5_35", 8'hC5, 8'h35, 1'b0, 2'b01, 1);
    run_cmp("12_13", 8'h12, 8'h13, 1'b0, 2'b10, 4);
    run_cmp("5a_5a", 8'h5A, 8'h5A, 1'b0, 2'b00, 4);
    run_cmp("00_ff", 8'h00, 8'hFF, 1'b0, 2'b10, 1);
    run_cmp("34_24", 8'h34, 8'h24, 1'b0, 2'b01, 2);
    run_cmp("a8_ac", 8'hA8, 8'hAC, 1'b0, 2'b10, 3);

    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++) begin
        logic [1:0] eo;
        eo = (x > y) ? 2'b01 : (x < y) ? 2'b10 : 2'b00;
        run_cmp($sformatf("sw_%0h_%0h", x, y), 8'(x), 8'(y), 1'b0, eo,
                first_diff(8'(x), 8'(y)));
      end

    // start while busy must be ignored
    a = 8'h12; b = 8'h13; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a = 8'hFF; b = 8'h00; start = 1'b1;
    tick();
    start = 1'b0;
    n = 2;
    while (!done && n < 20) begin tick(); n++; end
    check("ign_lat", n, 4);
    check("ign_o", o, 2'b10);
    tick();
    check("ign_ready", ready, 1'b1);
    tick();
    check("ign_no_rerun", {30'd0, busy, ready}, 32'd1);

    // reset mid-run after o holds a nonzero value
    a = 8'h12; b = 8'h13; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    check("rst_flags", {29'd0, ready, busy, done}, 32'd4);
    check("rst_o", o, 2'b00);
    tick();
    rst = 1'b0;
    tick();
    check("rst_idle", {29'd0, ready, busy, done}, 32'd4);
    run_cmp("post_rst", 8'hC5, 8'h35, 1'b0, 2'b01, 1);

`ifdef COMP_SERIAL_SIGNED_EN
    run_cmp("s_80_01", 8'h80, 8'h01, 1'b1, 2'b10, 1);
    run_cmp("u_80_01", 8'h80, 8'h01, 1'b0, 2'b01, 1);
    run_cmp("s_ff_fe", 8'hFF, 8'hFE, 1'b1, 2'b01, 4);
    run_cmp("s_40_c0", 8'h40, 8'hC0, 1'b1, 2'b01, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
